factorial_bcd_conv: RTL and testbench

// - Downstream stage of FactorialBlk: takes its 46-bit binary factorial result and converts it to packed BCD.
// - Also reports the count of significant decimal digits, for display/UART formatting stages.
// - Conversion is sequential double-dabble: one bit per cycle, one result in flight.

---
 rtl/factorial_pkg.sv | 17 +
 rtl/bcd_add3_digit.sv | 10 +
 rtl/factorial_bcd_conv.sv | 105 ++++++++++
 tb/tb_factorial_bcd_conv.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/factorial_pkg.sv
// Shared widths, FSM state encoding and BCD word type for the factorial
// result formatting stages.
package factorial_pkg;

  localparam int unsigned FACT_W     = 46;
  localparam int unsigned FACT_IN_W  = 4;
  localparam int unsigned BCD_DIGITS = 14;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } bcd_state_t;

  typedef logic [BCD_DIGITS*4-1:0] bcd_word_t;

endpackage

// File: rtl/bcd_add3_digit.sv
// Double-dabble digit correction: add 3 to a BCD digit of 5 or more so the
// following left shift carries correctly into the next decimal digit.
module bcd_add3_digit (
  input  logic [3:0] d,
  output logic [3:0] q
);

  assign q = (d >= 4'd5) ? d + 4'd3 : d;

endmodule

// File: rtl/factorial_bcd_conv.sv
// Sequential double-dabble converter: turns a binary factorial result into
// packed BCD, one bit per cycle, and reports the significant digit count.
module factorial_bcd_conv
  import factorial_pkg::*;
#(
  parameter int unsigned BIN_W  = FACT_W,
  parameter int unsigned DIGITS = BCD_DIGITS
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [BIN_W-1:0]      in_data,
  input  logic                  in_valid,
  output logic [DIGITS*4-1:0]   out_bcd,
  output logic [3:0]            out_ndigits,
  output logic                  out_valid,
  output logic                  out_busy
);

  localparam int unsigned CNT_W = $clog2(BIN_W + 1);
  localparam int unsigned ACC_W = DIGITS * 4;
  // ceil(BIN_W * log10(2)) in integer arithmetic
  localparam int unsigned MIN_DIGITS = (BIN_W * 30103 + 99999) / 100000;

  if (DIGITS < MIN_DIGITS) begin : g_digits_check
    $error("DIGITS too small for BIN_W");
  end

  bcd_state_t       state_q, state_d;
  logic [BIN_W-1:0] bin_q;
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_adj;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       ndigits;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3_digit u_add3 (
      .d (acc_q[4*g +: 4]),
      .q (acc_adj[4*g +: 4])
    );
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid) state_d = SHIFT;
      SHIFT:   if (cnt_q == CNT_W'(1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    out_busy = (state_q != IDLE);
  end

  // Highest nonzero digit wins; an all-zero result still shows one digit.
  always_comb begin
    ndigits = 4'd1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (acc_q[4*i +: 4] != 4'd0) ndigits = 4'(i + 1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bin_q       <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_bcd     <= '0;
      out_ndigits <= 4'd1;
      out_valid   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            bin_q <= in_data;
            acc_q <= '0;
            cnt_q <= CNT_W'(BIN_W);
          end
        end
        SHIFT: begin
          acc_q <= {acc_adj[ACC_W-2:0], bin_q[BIN_W-1]};
          bin_q <= {bin_q[BIN_W-2:0], 1'b0};
          cnt_q <= cnt_q - CNT_W'(1);
        end
        DONE: begin
          out_bcd     <= acc_q;
          out_ndigits <= ndigits;
          out_valid   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_factorial_bcd_conv.sv
// Directed bench for factorial_bcd_conv: table of conversions plus
// hand-written sequences for drop, reset abort and back-to-back captures.
module tb_factorial_bcd_conv;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [45:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic [55:0] out_bcd;
  logic [3:0]  out_ndigits;
  logic        out_valid;
  logic        out_busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [45:0] val;
    logic [55:0] bcd;
    logic [3:0]  nd;
  } vec_t;

  vec_t vecs [7];

  always #5 clk = ~clk;

  factorial_bcd_conv dut (
    .clk         (clk),
    .resetn      (resetn),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .out_bcd     (out_bcd),
    .out_ndigits (out_ndigits),
    .out_valid   (out_valid),
    .out_busy    (out_busy)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Capture val, then wait (bounded) for the result pulse.
  task automatic convert(input logic [45:0] val, output int lat);
    @(negedge clk);
    in_data  = val;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    check("busy_after_capture", 64'(out_busy), 64'd1);
    in_valid = 1'b0;
    in_data  = {$urandom, $urandom};
    lat = -1;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    int pulses;
    int first;
    int second;
    logic [55:0] bcd0;

    vecs[0] = '{46'd6,              56'h6,              4'd1};
    vecs[1] = '{46'd1307674368000,  56'h1307674368000,  4'd13};
    vecs[2] = '{46'h3FFF_FFFF_FFFF, 56'h70368744177663, 4'd14};
    vecs[3] = '{46'd0,              56'h0,              4'd1};
    vecs[4] = '{46'd120,            56'h120,            4'd3};
    vecs[5] = '{46'd10,             56'h10,             4'd2};
    vecs[6] = '{46'd99999,          56'h99999,          4'd5};

    #12;
    check("reset_bcd", 64'(out_bcd), 64'd0);
    check("reset_ndigits", 64'(out_ndigits), 64'd1);
    check("reset_valid", 64'(out_valid), 64'd0);
    check("reset_busy", 64'(out_busy), 64'd0);
    @(negedge clk);
    resetn = 1'b1;

    for (int v = 0; v < 7; v++) begin
      convert(vecs[v].val, lat);
      check("latency", 64'(lat), 64'd47);
      check("busy_at_valid", 64'(out_busy), 64'd0);
      check("bcd", 64'(out_bcd), 64'(vecs[v].bcd));
      check("ndigits", 64'(out_ndigits), 64'(vecs[v].nd));
      @(posedge clk);
      #1;
      check("valid_one_cycle", 64'(out_valid), 64'd0);
      check("bcd_held", 64'(out_bcd), 64'(vecs[v].bcd));
    end

    // Request while busy is dropped.
    @(negedge clk);
    in_data  = 46'd120;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    pulses = 0;
    first  = -1;
    for (int k = 1; k <= 110; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        pulses++;
        if (first < 0) begin
          first = k;
          bcd0  = out_bcd;
        end
      end
      if (k == 9) begin
        in_data  = 46'd3;
        in_valid = 1'b1;
      end else if (k == 10) begin
        in_valid = 1'b0;
      end
    end
    check("drop_pulses", 64'(pulses), 64'd1);
    check("drop_latency", 64'(first), 64'd47);
    check("drop_bcd", 64'(bcd0), 64'h120);

    // Reset mid-conversion aborts with no result.
    @(negedge clk);
    in_data  = 46'd720;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
    end
    resetn = 1'b0;
    #1;
    check("abort_bcd", 64'(out_bcd), 64'd0);
    check("abort_ndigits", 64'(out_ndigits), 64'd1);
    check("abort_valid", 64'(out_valid), 64'd0);
    check("abort_busy", 64'(out_busy), 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    pulses = 0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) pulses++;
    end
    check("abort_no_valid", 64'(pulses), 64'd0);
    convert(46'd24, lat);
    check("after_abort_latency", 64'(lat), 64'd47);
    check("after_abort_bcd", 64'(out_bcd), 64'h24);
    check("after_abort_ndigits", 64'(out_ndigits), 64'd2);

    // in_valid held high: 6 then 24, second taken in the out_valid cycle.
    @(negedge clk);
    in_data  = 46'd6;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_data = 46'd24;
    first   = -1;
    second  = -1;
    pulses  = 0;
    for (int k = 1; k <= 120; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        pulses++;
        if (first < 0) begin
          first = k;
          check("b2b_first_bcd", 64'(out_bcd), 64'h6);
          check("b2b_first_nd", 64'(out_ndigits), 64'd1);
        end else if (second < 0) begin
          second = k;
          in_valid = 1'b0;
          check("b2b_second_bcd", 64'(out_bcd), 64'h24);
          check("b2b_second_nd", 64'(out_ndigits), 64'd2);
        end
      end
    end
    in_valid = 1'b0;
    check("b2b_pulses", 64'(pulses), 64'd2);
    check("b2b_first_lat", 64'(first), 64'd47);
    check("b2b_spacing", 64'(second - first), 64'd48);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
